// File: rtl/iram_mc_if.sv
// Bus bundle between the program loader / core fetch units and the shared
// instruction memory iram_mc.
//
//   master : loader and fetch side (drives writes and fetch requests)
//   slave  : memory side (returns grants, fetch data and error flags)
//
// Signals:
//   wr_en, wr_addr, wr_data : program-load write port
//   rd_req   [NUM_CORES]    : per-core fetch request, held until granted
//   rd_addr  [NUM_CORES*A]  : per-core fetch address, core i at [i*ADDR_W +: ADDR_W]
//   rd_gnt   [NUM_CORES]    : one-hot combinational grant
//   rd_valid [NUM_CORES]    : one-cycle data-ready pulse
//   rd_data  [NUM_CORES*D]  : per-core held fetch data
//   rd_oor   [NUM_CORES]    : last fetch for core i was out of range
//   wr_err                  : one-cycle pulse, out-of-range write dropped
interface iram_mc_if #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned NUM_CORES = 4
);

  logic                          wr_en;
  logic [ADDR_W-1:0]             wr_addr;
  logic [DATA_W-1:0]             wr_data;
  logic [NUM_CORES-1:0]          rd_req;
  logic [NUM_CORES*ADDR_W-1:0]   rd_addr;
  logic [NUM_CORES-1:0]          rd_gnt;
  logic [NUM_CORES-1:0]          rd_valid;
  logic [NUM_CORES*DATA_W-1:0]   rd_data;
  logic [NUM_CORES-1:0]          rd_oor;
  logic                          wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, rd_req, rd_addr,
    input  rd_gnt, rd_valid, rd_data, rd_oor, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req, rd_addr,
    output rd_gnt, rd_valid, rd_data, rd_oor, wr_err
  );

endinterface

// File: rtl/iram_mc.sv
// Shared instruction memory for NUM_CORES fetch units.
//
// A single-ported array serves one access per cycle: a program-load write
// (which always wins) or one round-robin arbitrated core fetch. Fetch data is
// captured into a per-core holding lane at the grant edge, so it appears with a
// one-cycle rd_valid pulse in the following cycle and stays until that core's
// next completed fetch. Out-of-range fetches return NOP_WORD with rd_oor set;
// out-of-range writes are dropped and flagged with a wr_err pulse.
//
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset (array contents are not cleared)
//   bus   : iram_mc_if slave modport (write port, fetch channels, status)
module iram_mc #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned NOP_WORD  = 41
) (
  input logic        clk,
  input logic        rst_n,
  iram_mc_if.slave   bus
);

  localparam int unsigned PtrW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] Nop = DATA_W'(NOP_WORD);
  localparam logic [PtrW-1:0] LastCore = PtrW'(NUM_CORES - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return 64'(addr) < 64'(DEPTH);
  endfunction

  // ---------------------------------------------------------------------------
  // Storage array (no reset: program image survives a core-complex reset)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic            wr_ok;
  logic [IdxW-1:0] wr_idx;

  assign wr_ok  = bus.wr_en && in_range(bus.wr_addr);
  assign wr_idx = bus.wr_addr[IdxW-1:0];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_idx] <= bus.wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [PtrW-1:0]      gnt_idx;
  logic [PtrW-1:0]      cand;
  logic                 gnt_any;
  logic [NUM_CORES-1:0] gnt;

  // Scan from the pointer upward with wrap; the first requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = PtrW'((32'(ptr_q) + 32'(k)) % NUM_CORES);
      if (!gnt_any && bus.rd_req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    // The write port owns the array this cycle.
    if (bus.wr_en) begin
      gnt_any = 1'b0;
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      gnt[i] = gnt_any && (gnt_idx == PtrW'(i));
    end
  end

  assign bus.rd_gnt = gnt;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == LastCore) ? '0 : gnt_idx + PtrW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch path: select granted address, read array or substitute NOP
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_ok;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (gnt_idx == PtrW'(i)) begin
        sel_addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign sel_ok  = in_range(sel_addr);
  assign rd_word = sel_ok ? mem_q[sel_addr[IdxW-1:0]] : Nop;

  // ---------------------------------------------------------------------------
  // Per-core holding lanes and status
  // ---------------------------------------------------------------------------
  logic [NUM_CORES*DATA_W-1:0] data_q, data_d;
  logic [NUM_CORES-1:0]        oor_q, oor_d;
  logic [NUM_CORES-1:0]        valid_q;
  logic                        wr_err_q;

  // Only the granted lane is reloaded; all others keep their last fetch.
  always_comb begin
    data_d = data_q;
    oor_d  = oor_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (gnt[i]) begin
        data_d[i*DATA_W +: DATA_W] = rd_word;
        oor_d[i]                   = !sel_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      valid_q  <= '0;
      oor_q    <= '0;
      data_q   <= {NUM_CORES{Nop}};
      wr_err_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      valid_q  <= gnt;
      oor_q    <= oor_d;
      data_q   <= data_d;
      wr_err_q <= bus.wr_en && !wr_ok;
    end
  end

  assign bus.rd_valid = valid_q;
  assign bus.rd_data  = data_q;
  assign bus.rd_oor   = oor_q;
  assign bus.wr_err   = wr_err_q;

  // ---------------------------------------------------------------------------
  // Checks
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_gnt_no_wr  : assert property (@(posedge clk) disable iff (!rst_n) bus.wr_en |-> gnt == '0);
  a_gnt_req    : assert property (@(posedge clk) disable iff (!rst_n)
                                 (gnt & ~bus.rd_req) == '0);
  a_vld_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(valid_q));
`endif

endmodule

// File: tb/tb_iram_mc.sv
module tb_iram_mc;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 4096;
  localparam int NC    = 4;
  localparam int NOP   = 41;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  iram_mc_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_CORES(NC)) bus ();

  iram_mc #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .NUM_CORES(NC),
    .NOP_WORD (NOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          core;
    logic [15:0] data;
    bit          oor;
    int          due;
  } rd_exp_t;

  rd_exp_t     rq[$];
  int          wq[$];
  logic [15:0] mem_m [int];
  int          m_ptr = 0;
  logic [NC-1:0] m_gnt = '0;
  logic [15:0] lane_exp [NC];
  bit          oor_exp  [NC];

  // Driver state
  bit          pend  [NC];
  logic [15:0] paddr [NC];
  bit          we;
  logic [15:0] wa, wd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: round-robin choice = requester closest at or after the
  // pointer, writes win, array kept as an associative array.
  initial begin
    int g, best, d, a;
    logic [NC-1:0] e;
    rd_exp_t r;
    for (int i = 0; i < NC; i++) begin
      lane_exp[i] = 16'(NOP);
      oor_exp[i]  = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rq.delete();
        wq.delete();
        m_ptr = 0;
        m_gnt = '0;
        for (int i = 0; i < NC; i++) begin
          lane_exp[i] = 16'(NOP);
          oor_exp[i]  = 1'b0;
        end
      end else begin
        g    = -1;
        best = NC;
        if (!bus.wr_en) begin
          for (int i = 0; i < NC; i++) begin
            if (bus.rd_req[i]) begin
              d = (i - m_ptr + NC) % NC;
              if (d < best) begin
                best = d;
                g    = i;
              end
            end
          end
        end
        e = '0;
        if (g >= 0) e[g] = 1'b1;
        chk("rd_gnt", 64'(bus.rd_gnt), 64'(e));
        m_gnt = e;
        if (bus.wr_en) begin
          a = int'(bus.wr_addr);
          if (a < DEPTH) mem_m[a] = bus.wr_data;
          else wq.push_back(cyc + 1);
        end else if (g >= 0) begin
          a      = int'(bus.rd_addr[g*AW +: AW]);
          r.core = g;
          r.oor  = (a >= DEPTH);
          r.data = r.oor ? 16'(NOP) : mem_m[a];
          r.due  = cyc + 1;
          rq.push_back(r);
          m_ptr = (g + 1) % NC;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard queues.
  initial begin
    logic [NC-1:0] ev;
    rd_exp_t r;
    bit ew;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_valid", 64'(bus.rd_valid), 64'(0));
        chk("rst_oor", 64'(bus.rd_oor), 64'(0));
        chk("rst_wr_err", 64'(bus.wr_err), 64'(0));
        for (int i = 0; i < NC; i++)
          chk($sformatf("rst_lane%0d", i), 64'(bus.rd_data[i*DW +: DW]), 64'(NOP));
      end else begin
        ev = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          r = rq.pop_front();
          ev[r.core]       = 1'b1;
          lane_exp[r.core] = r.data;
          oor_exp[r.core]  = r.oor;
        end
        chk("rd_valid", 64'(bus.rd_valid), 64'(ev));
        for (int i = 0; i < NC; i++)
          chk($sformatf("lane%0d", i), {47'd0, bus.rd_oor[i], bus.rd_data[i*DW +: DW]},
              {47'd0, oor_exp[i], lane_exp[i]});
        ew = 1'b0;
        if (wq.size() > 0 && wq[0] == cyc) begin
          void'(wq.pop_front());
          ew = 1'b1;
        end
        chk("wr_err", 64'(bus.wr_err), 64'(ew));
      end
    end
  end

  // One cycle: apply inputs, wait for the edge, retire granted requests.
  task automatic step();
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    for (int i = 0; i < NC; i++) begin
      bus.rd_req[i]           = pend[i];
      bus.rd_addr[i*AW +: AW] = paddr[i];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) if (m_gnt[i]) pend[i] = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    we = 1'b1;
    wa = 16'(a);
    wd = 16'(d);
    step();
    we = 1'b0;
  endtask

  task automatic req(input int c, input int a);
    pend[c]  = 1'b1;
    paddr[c] = 16'(a);
  endtask

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int i = 0; i < NC; i++) r |= pend[i];
    return r;
  endfunction

  task automatic drain();
    int n = 0;
    while (any_pend() && n < 40) begin
      step();
      n++;
    end
    if (any_pend()) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain @cyc %0d: requests still pending after %0d cycles, expected 0", cyc, n);
      for (int i = 0; i < NC; i++) pend[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    we = 1'b0;
    for (int i = 0; i < NC; i++) pend[i] = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  function automatic int rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 63);
    if (r < 9) return $urandom_range(4088, 4095);
    case ($urandom_range(0, 3))
      0:       return 4096;
      1:       return 5000;
      2:       return 65535;
      default: return 4096 + $urandom_range(0, 999);
    endcase
  endfunction

  initial begin
    int n;
    we = 1'b0;
    wa = '0;
    wd = '0;
    for (int i = 0; i < NC; i++) begin
      pend[i]  = 1'b0;
      paddr[i] = '0;
    end
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req  = '0;
    bus.rd_addr = '0;
    #1;
    do_reset();

    // Basic write then read
    wr(130, 7);
    req(0, 130);
    drain();

    // Preload the address window used by random fetches
    for (int a = 0; a < 64; a++) wr(a, $urandom_range(0, 65535));
    for (int a = 4088; a < 4096; a++) wr(a, $urandom_range(0, 65535));

    // All cores requesting continuously from reset
    do_reset();
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < NC; c++) if (!pend[c]) req(c, $urandom_range(0, 63));
      step();
    end
    drain();

    // Writes hold off pending fetches from cores 1 and 2
    do_reset();
    req(1, 11);
    req(2, 4090);
    wr(20, 100);
    wr(21, 101);
    wr(22, 102);
    drain();

    // Read-after-write, same address
    wr(5, 17);
    req(3, 5);
    drain();

    // Out-of-range fetch and dropped out-of-range writes
    req(2, 4096);
    drain();
    wr(5000, 999);
    wr(4101, 555);
    req(0, 5);
    drain();

    // Reset right after a grant to core1
    req(1, 10);
    n = 0;
    while (pend[1] && n < 10) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int c = 0; c < NC; c++) req(c, (c == 0) ? 130 : $urandom_range(0, 63));
    drain();

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        we = 1'b1;
        wa = ($urandom_range(0, 7) == 0) ? 16'(4096 + $urandom_range(0, 60000))
                                         : 16'($urandom_range(0, 63));
        wd = 16'($urandom_range(0, 65535));
      end else begin
        we = 1'b0;
      end
      for (int c = 0; c < NC; c++)
        if (!pend[c] && $urandom_range(0, 1) == 1) req(c, rand_addr());
      step();
    end
    we = 1'b0;
    drain();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iram_mc.md
Name: iram_mc

Overview:
- Parametrised instruction memory shared by NUM_CORES processor cores.
- Single-ported storage array with a synchronous program-load write port and round-robin arbitrated per-core read channels.
- One-cycle read latency; per-core data holding registers.
- Out-of-range fetches return a NOP word and flag an error.
- Sits between the program loader and the core fetch units.

Parameters:
DATA_W, 16, instruction word width
ADDR_W, 16, address width of all address ports
DEPTH, 4096, number of implemented words (must be ≤ 2^ADDR_W)
NUM_CORES, 4, number of read channels (≥1)
NOP_WORD, 41, word returned on reset and on out-of-range fetch

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  program-load write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_req  in  NUM_CORES  per-core fetch request (level, held until granted)
rd_addr  in  NUM_CORES*ADDR_W  per-core fetch address, core i at bits [i*ADDR_W +: ADDR_W]
rd_gnt  out  NUM_CORES  one-hot combinational grant
rd_valid  out  NUM_CORES  one-cycle pulse, data ready
rd_data  out  NUM_CORES*DATA_W  per-core held fetch data
rd_oor  out  NUM_CORES  last fetch for core i was out of range (held with rd_data)
wr_err  out  1  one-cycle pulse, write to address ≥ DEPTH dropped

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - rd_valid=0, rd_oor=0, wr_err=0.
  - Every rd_data lane = NOP_WORD.
  - RR pointer = 0.
  - Pending read discarded.
  - Memory contents NOT cleared.
- Write priority: wr_en=1 in cycle T → rd_gnt=0 for all cores in T, and the array writes at the T edge.
  - wr_addr ≥ DEPTH: no write; wr_err=1 in T+1.
- Arbitration, when wr_en=0 and any rd_req set:
  - Grant the first requesting core searching from RR pointer upward, wrapping at NUM_CORES-1 → 0.
  - rd_gnt is one-hot and combinational in the same cycle.
  - At the edge, pointer := granted index + 1 (mod NUM_CORES).
  - No request → pointer unchanged.
- Handshake:
  - Core keeps rd_req and rd_addr stable until it sees rd_gnt.
  - It may drop or re-issue in the cycle after the grant.
  - Back-to-back grants to the same core are allowed only when it is the sole requester.
- Latency: grant at T → rd_valid[i]=1 in T+1, with rd_data lane i = mem[addr] and rd_oor[i]=0.
  - rd_valid is a single-cycle pulse.
  - rd_data and rd_oor hold until the next completed fetch for that core.
- Out of range: granted addr ≥ DEPTH → in T+1, rd_data lane = NOP_WORD, rd_oor[i]=1, rd_valid[i]=1. The array is not accessed.
- Read-after-write:
  - Write at T, read granted at T+1 to the same address → returns the new data.
  - No same-cycle bypass needed, because write and grant are exclusive.
- Throughput: one access (read or write) per cycle total.
- Starvation bound: any held request is granted within NUM_CORES cycles, excluding cycles occupied by writes.
- Reset mid-operation: a grant at T followed by reset before the T+1 edge → no rd_valid, lanes = NOP_WORD.
- NUM_CORES=1: arbiter degenerates; grant = rd_req & ~wr_en.

Test Plan:
- Reset → all rd_data lanes = 41, rd_valid=0, rd_oor=0; write mem[130]=7, core0 reads 130 → rd_valid[0] one cycle later, rd_data lane0 = 7.
- All 4 cores request continuously from reset → grants in order 0,1,2,3,0,…; each rd_valid exactly one cycle after its grant.
- wr_en held 3 cycles while cores 1 and 2 request → no grants during writes; then core1 granted, followed by core2.
- Write mem[5]=17 at T, core3 reads 5 at T+1 → lane3 = 17 at T+2.
- Core2 reads address 4096 (DEPTH=4096) → lane2 = 41, rd_oor[2]=1; write to 5000 → wr_err pulse, mem unchanged.
- Assert rst_n=0 in the cycle after a grant to core1 → no rd_valid[1]; lane1 = 41 after reset; RR pointer restarts at core0.
